// File: rtl/display_timings.sv
// display_timings: raster timing generator for the pixel pipeline.
// Produces signed screen coordinates (negative during blanking), sync
// pulses, data-enable and line/frame start strobes. Every output is a
// register loaded together with the counters, so the flags line up
// exactly with sx/sy.
// Optional build macro DISPLAY_TIMINGS_FRAME_CNT_EN adds a 16-bit
// frame counter output (frame_cnt) that advances on each frame strobe.
module display_timings #(
  parameter int CORDW  = 16,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    ce,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    line,
  output logic                    frame
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  // Window boundaries, worked out in int and narrowed once.
  localparam int H_STA_I  = -(H_FP + H_SYNC + H_BP);
  localparam int HS_STA_I = H_STA_I + H_FP;
  localparam int HS_END_I = HS_STA_I + H_SYNC;
  localparam int HA_END_I = H_RES - 1;
  localparam int V_STA_I  = -(V_FP + V_SYNC + V_BP);
  localparam int VS_STA_I = V_STA_I + V_FP;
  localparam int VS_END_I = VS_STA_I + V_SYNC;
  localparam int VA_END_I = V_RES - 1;

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(HS_STA_I);
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(HS_END_I);
  localparam logic signed [CORDW-1:0] HA_END = CORDW'(HA_END_I);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(VS_STA_I);
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(VS_END_I);
  localparam logic signed [CORDW-1:0] VA_END = CORDW'(VA_END_I);
  localparam logic signed [CORDW-1:0] ZERO   = '0;
  localparam logic        [CORDW-1:0] ONE    = CORDW'(1);

  logic signed [CORDW-1:0] sx_q, sx_d;
  logic signed [CORDW-1:0] sy_q, sy_d;
  logic                    hs_q, hs_d;
  logic                    vs_q, vs_d;
  logic                    de_q, de_d;
  logic                    line_q, line_d;
  logic                    frame_q, frame_d;

  // Next counter values and flags decoded from those next values, so the
  // registered flags describe the coordinate loaded alongside them.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (ce) begin
      if (sx_q == HA_END) begin
        sx_d = H_STA;
        sy_d = (sy_q == VA_END) ? V_STA : (sy_q + ONE);
      end else begin
        sx_d = sx_q + ONE;
      end
      hs_d    = (sx_d >= HS_STA && sx_d < HS_END) ? H_POL : ~H_POL;
      vs_d    = (sy_d >= VS_STA && sy_d < VS_END) ? V_POL : ~V_POL;
      de_d    = (sx_d >= ZERO && sx_d <= HA_END && sy_d >= ZERO && sy_d <= VA_END);
      line_d  = (sx_d == H_STA);
      frame_d = (sx_d == H_STA) && (sy_d == V_STA);
    end
  end

  // Counter and output registers; reset parks at the top-left blanking corner.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      sx_q    <= H_STA;
      sy_q    <= V_STA;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign de    = de_q;
  assign line  = line_q;
  assign frame = frame_q;

`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  // Frame counter loads together with the frame strobe, so it already
  // shows the new count while frame is high.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      fcnt_q <= 16'h0000;
    end else if (frame_d) begin
      fcnt_q <= fcnt_q + 16'h0001;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule
